// File: rtl/write_fifo_pkg.sv
// Shared helpers for the write FIFO: depth derivation and pointer compares.
// Pointers are ADDR_W+1 bits wide; the extra MSB tells a full FIFO apart
// from an empty one when the low address bits coincide.
package write_fifo_pkg;

  // Number of entries for a given address width (power of two only).
  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  // Full: pointer MSBs differ while all lower address bits are equal.
  function automatic logic ptr_full(input int unsigned wr, input int unsigned rd,
                                    input int unsigned aw);
    return (wr ^ rd) == (32'd1 << aw);
  endfunction

  // Empty: both pointers identical, including the wrap bit.
  function automatic logic ptr_empty(input int unsigned wr, input int unsigned rd);
    return wr == rd;
  endfunction

endpackage

// File: rtl/write_fifo_ram.sv
// Simple dual-port storage for write_fifo: synchronous write, synchronous
// read with read enable. The read register holds its value while re is low
// and clears on reset so the FIFO output starts at zero; the array itself
// is never cleared.
module write_fifo_ram
  import write_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; holds last word when not reading.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/write_fifo.sv
// Synchronous FIFO buffering the arbitrated write stream for a single reader.
// Pointer and status control lives here; storage is in write_fifo_ram.
// All status outputs are registered and derived from the next-state pointers,
// so they track the pointers with no extra lag.
// Optional sticky overflow/underflow flags: define WRITE_FIFO_ERR_EN.
module write_fifo
  import write_fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 3,
  parameter int AF_MARGIN = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_full,
  output logic              o_almost_full,
  input  logic              i_re,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_W);
  localparam int          PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] AF_THRESH = PTR_W'(DEPTH - AF_MARGIN);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_ptr_n, rd_ptr_n, count_n;
  logic             wr_acc, rd_acc;

  // Accept decisions use the registered flags: no fall-through when empty,
  // no pass-through when full. Nothing is accepted during reset.
  assign wr_acc = i_we & ~o_full  & ~i_reset;
  assign rd_acc = i_re & ~o_empty & ~i_reset;

  // Next pointers and fill level.
  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    if (wr_acc) wr_ptr_n = wr_ptr + 1'b1;
    if (rd_acc) rd_ptr_n = rd_ptr + 1'b1;
    count_n = wr_ptr_n - rd_ptr_n;
  end

  // Pointer and status registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      o_count       <= '0;
      o_empty       <= 1'b1;
      o_full        <= 1'b0;
      o_almost_full <= 1'b0;
      o_rvalid      <= 1'b0;
    end else begin
      wr_ptr        <= wr_ptr_n;
      rd_ptr        <= rd_ptr_n;
      o_count       <= count_n;
      o_empty       <= ptr_empty(32'(wr_ptr_n), 32'(rd_ptr_n));
      o_full        <= ptr_full(32'(wr_ptr_n), 32'(rd_ptr_n), ADDR_W);
      o_almost_full <= (count_n >= AF_THRESH);
      o_rvalid      <= rd_acc;
    end
  end

  write_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (i_clk),
    .rst   (i_reset),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (i_wdata),
    .re    (rd_acc),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (o_rdata)
  );

`ifdef WRITE_FIFO_ERR_EN
  // Sticky error flags: any write attempt while full, any read while empty.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_we & o_full)  o_overflow  <= 1'b1;
      if (i_re & o_empty) o_underflow <= 1'b1;
    end
  end
`else
  assign o_overflow  = 1'b0;
  assign o_underflow = 1'b0;
`endif

`ifdef FORMAL
  // Structural invariants of the pointer/flag bookkeeping.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      assert (o_count <= PTR_W'(DEPTH));
      assert (!(o_full && o_empty));
      assert (o_count == PTR_W'(wr_ptr - rd_ptr));
    end
  end
`endif

endmodule

// File: tb/tb_write_fifo.sv
// Directed bench for write_fifo (DATA_W=8, ADDR_W=3, AF_MARGIN=1).
// A queue model of the FIFO contents predicts acceptance; every accepted
// read pushes its expected word onto a scoreboard that is popped when the
// DUT raises o_rvalid.
module tb_write_fifo;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
  localparam int AF_LVL = DEPTH - 1;

  logic              i_clk;
  logic              i_reset;
  logic              i_we;
  logic [DATA_W-1:0] i_wdata;
  logic              o_full;
  logic              o_almost_full;
  logic              i_re;
  logic [DATA_W-1:0] o_rdata;
  logic              o_rvalid;
  logic              o_empty;
  logic [ADDR_W:0]   o_count;
  logic              o_overflow;
  logic              o_underflow;

  write_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_MARGIN(1)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_we          (i_we),
    .i_wdata       (i_wdata),
    .o_full        (o_full),
    .o_almost_full (o_almost_full),
    .i_re          (i_re),
    .o_rdata       (o_rdata),
    .o_rvalid      (o_rvalid),
    .o_empty       (o_empty),
    .o_count       (o_count),
    .o_overflow    (o_overflow),
    .o_underflow   (o_underflow)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mq[$];     // model of stored contents
  logic [DATA_W-1:0] sb[$];     // expected read data scoreboard
  logic [DATA_W-1:0] last_rd;   // model of held o_rdata
  logic              ovf_m, unf_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all status outputs against the model.
  task automatic chk_status(input string tag);
    chk({tag, ":count"}, 32'(o_count), 32'(mq.size()));
    chk({tag, ":empty"}, 32'(o_empty), 32'(mq.size() == 0));
    chk({tag, ":full"},  32'(o_full),  32'(mq.size() == DEPTH));
    chk({tag, ":afull"}, 32'(o_almost_full), 32'(mq.size() >= AF_LVL));
    chk({tag, ":ovf"},   32'(o_overflow),  32'(ovf_m));
    chk({tag, ":unf"},   32'(o_underflow), 32'(unf_m));
  endtask

  // One clock with the given strobes; model updated, then outputs checked.
  task automatic cyc(input string tag, input logic we, input logic [DATA_W-1:0] wd,
                     input logic re);
    logic m_full, m_empty, wacc, racc;
    i_we = we; i_wdata = wd; i_re = re;
    m_full  = (mq.size() == DEPTH);
    m_empty = (mq.size() == 0);
    wacc = we && !m_full;
    racc = re && !m_empty;
`ifdef WRITE_FIFO_ERR_EN
    if (we && m_full)  ovf_m = 1'b1;
    if (re && m_empty) unf_m = 1'b1;
`endif
    if (racc) sb.push_back(mq.pop_front());
    if (wacc) mq.push_back(wd);
    @(posedge i_clk); #1;
    i_we = 1'b0; i_re = 1'b0;
    chk({tag, ":rvalid"}, 32'(o_rvalid), 32'(racc));
    if (o_rvalid) begin
      if (sb.size() == 0) begin
        chk({tag, ":sb_empty"}, 32'd1, 32'd0);
      end else begin
        last_rd = sb.pop_front();
      end
    end
    chk({tag, ":rdata"}, 32'(o_rdata), 32'(last_rd));
    chk_status(tag);
  endtask

  task automatic do_reset(input int n);
    i_reset = 1'b1; i_we = 1'b1; i_wdata = 8'h55; i_re = 1'b1;
    repeat (n) @(posedge i_clk);
    #1;
    mq.delete(); sb.delete();
    last_rd = '0; ovf_m = 1'b0; unf_m = 1'b0;
    chk("reset:rvalid", 32'(o_rvalid), 32'd0);
    chk("reset:rdata",  32'(o_rdata),  32'd0);
    chk_status("reset");
    i_reset = 1'b0; i_we = 1'b0; i_re = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1; i_we = 1'b0; i_re = 1'b0; i_wdata = '0;
    last_rd = '0; ovf_m = 1'b0; unf_m = 1'b0;

    // 1: reset held two clocks with write strobe active
    do_reset(2);

    // 2: fill with 0x11..0x88, one rejected write, then drain
    for (int i = 1; i <= 8; i++) cyc("fill", 1'b1, 8'(i * 8'h11), 1'b0);
    cyc("fill_rej", 1'b1, 8'h99, 1'b0);
    for (int i = 0; i < 8; i++) cyc("drain", 1'b0, 8'h00, 1'b1);
    cyc("idle", 1'b0, 8'h00, 1'b0);

    // 3: wrap-around with two bursts
    for (int i = 0; i < 5; i++) cyc("wrap_w5", 1'b1, 8'(8'hA0 + i), 1'b0);
    for (int i = 0; i < 5; i++) cyc("wrap_r5", 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) cyc("wrap_w6", 1'b1, 8'(8'hB0 + i), 1'b0);
    for (int i = 0; i < 6; i++) cyc("wrap_r6", 1'b0, 8'h00, 1'b1);
    cyc("wrap_idle", 1'b0, 8'h00, 1'b0);

    // 4: simultaneous read+write at count 4
    for (int i = 0; i < 4; i++) cyc("sim_pre", 1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 10; i++) cyc("sim_rw", 1'b1, 8'(8'hC0 + i), 1'b1);
    for (int i = 0; i < 4; i++) cyc("sim_post", 1'b0, 8'h00, 1'b1);
    cyc("sim_idle", 1'b0, 8'h00, 1'b0);

    // 5: full + read + write, then empty + read + write
    for (int i = 0; i < 8; i++) cyc("full_pre", 1'b1, 8'(8'h60 + i), 1'b0);
    cyc("full_rw", 1'b1, 8'hAA, 1'b1);
    for (int i = 0; i < 7; i++) cyc("full_post", 1'b0, 8'h00, 1'b1);
    cyc("empty_rw", 1'b1, 8'h5A, 1'b1);
    cyc("empty_rd", 1'b0, 8'h00, 1'b1);
    cyc("empty_idle", 1'b0, 8'h00, 1'b0);

    // 6: error flags (expected zero without WRITE_FIFO_ERR_EN)
    cyc("unf_rd", 1'b0, 8'h00, 1'b1);
    cyc("unf_hold", 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) cyc("ovf_pre", 1'b1, 8'(8'h70 + i), 1'b0);
    cyc("ovf_wr", 1'b1, 8'hEE, 1'b0);
    cyc("ovf_hold", 1'b0, 8'h00, 1'b1);

    // Reset with data stored discards contents and clears flags
    do_reset(1);
    cyc("post_rst_rd", 1'b0, 8'h00, 1'b1);
    cyc("post_rst_w", 1'b1, 8'h3C, 1'b0);
    cyc("post_rst_r", 1'b0, 8'h00, 1'b1);
    cyc("post_rst_idle", 1'b0, 8'h00, 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
